// File: rtl/tank_pkg.sv
// tank_pkg: heading encoding, screen/sprite dimensions and reset position shared by the tank sprite logic.
package tank_pkg;

    typedef enum logic [1:0] {
        HEAD_UP    = 2'b00,
        HEAD_RIGHT = 2'b01,
        HEAD_DOWN  = 2'b10,
        HEAD_LEFT  = 2'b11
    } heading_t;

    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SPRITE_SIZE = 60;

    localparam logic [9:0] RESET_X = 10'd290;
    localparam logic [9:0] RESET_Y = 10'd210;

endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer followed by a consecutive-mismatch counter debouncer.
module button_debounce
    import tank_pkg::*;
#(
    parameter int Debounce_Cycles = 250000
) (
    input  logic Master_Clock_In,
    input  logic Reset_In,
    input  logic button,
    output logic state
);

    localparam int CW = $clog2(Debounce_Cycles + 1);

    logic [1:0]    sync;
    logic [CW-1:0] count;

    // bring the raw button into the clock domain
    always_ff @(posedge Master_Clock_In or posedge Reset_In)
        if (Reset_In) sync <= '0;
        else          sync <= {sync[0], button};

    // accept the new level only after it has differed on every one of the last Debounce_Cycles clocks
    always_ff @(posedge Master_Clock_In or posedge Reset_In)
        if (Reset_In) begin
            state <= 1'b0;
            count <= '0;
        end else if (sync[1] == state) begin
            count <= '0;
        end else if (count == CW'(Debounce_Cycles - 1)) begin
            state <= sync[1];
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end

endmodule

// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: debounced button motion of a wrapping square sprite plus a 2-stage rotated sprite-ROM address pipeline.
module tank_motion_ctrl
    import tank_pkg::*;
#(
    parameter int Pixels_Horiz    = SCREEN_W,
    parameter int Pixels_Vert     = SCREEN_H,
    parameter int Sprite_Size     = SPRITE_SIZE,
    parameter int Debounce_Cycles = 250000
) (
    input  logic        Master_Clock_In,
    input  logic        Reset_In,
    input  logic        Frame_Tick_In,
    input  logic [9:0]  Val_Col_In,
    input  logic [9:0]  Val_Row_In,
    input  logic        Up,
    input  logic        Down,
    input  logic        Left,
    input  logic        Right,
    output logic [9:0]  xPosition_Out,
    output logic [9:0]  yPosition_Out,
    output logic [1:0]  Heading_Out,
    output logic        Sprite_Hit_Out,
    output logic [11:0] Sprite_Addr_Out
);

    localparam logic [9:0]  X_MAX = 10'(Pixels_Horiz - Sprite_Size);
    localparam logic [9:0]  Y_MAX = 10'(Pixels_Vert - Sprite_Size);
    localparam logic [9:0]  S1    = 10'(Sprite_Size - 1);
    localparam logic [10:0] S1W   = 11'(Sprite_Size - 1);
    localparam logic [11:0] SS    = 12'(Sprite_Size);

    logic [3:0] raw, db, btn_q;
    logic       pend;
    logic [9:0] x_q, y_q, x_nxt, y_nxt;
    heading_t   head_q, head_nxt;
    logic       mv_u, mv_d, mv_l, mv_r;

    assign raw = {Up, Down, Left, Right};

    for (genvar i = 0; i < 4; i++) begin : g_db
        button_debounce #(.Debounce_Cycles(Debounce_Cycles)) u_db (
            .Master_Clock_In(Master_Clock_In),
            .Reset_In       (Reset_In),
            .button         (raw[i]),
            .state          (db[i])
        );
    end

    assign mv_u = btn_q[3] & ~btn_q[2];
    assign mv_d = btn_q[2] & ~btn_q[3];
    assign mv_l = btn_q[1] & ~btn_q[0];
    assign mv_r = btn_q[0] & ~btn_q[1];

    // capture buttons on the tick, apply one step the following cycle
    always_ff @(posedge Master_Clock_In or posedge Reset_In)
        if (Reset_In) begin
            pend   <= 1'b0;
            btn_q  <= '0;
            x_q    <= RESET_X;
            y_q    <= RESET_Y;
            head_q <= HEAD_UP;
        end else begin
            pend <= Frame_Tick_In;
            if (Frame_Tick_In) btn_q <= db;
            x_q    <= x_nxt;
            y_q    <= y_nxt;
            head_q <= head_nxt;
        end

    // next position with wrap-around; out-of-range values fold back onto the grid
    always_comb begin
        x_nxt    = x_q;
        y_nxt    = y_q;
        head_nxt = head_q;
        if (pend) begin
            x_nxt    = mv_l ? ((x_q == '0 || x_q > X_MAX) ? X_MAX : x_q - 1'b1) :
                       mv_r ? ((x_q >= X_MAX) ? '0 : x_q + 1'b1) : x_q;
            y_nxt    = mv_u ? ((y_q == '0 || y_q > Y_MAX) ? Y_MAX : y_q - 1'b1) :
                       mv_d ? ((y_q >= Y_MAX) ? '0 : y_q + 1'b1) : y_q;
            head_nxt = mv_u ? HEAD_UP : mv_d ? HEAD_DOWN : mv_r ? HEAD_RIGHT : mv_l ? HEAD_LEFT : head_q;
        end
    end

    assign xPosition_Out = x_q;
    assign yPosition_Out = y_q;
    assign Heading_Out   = head_q;

    logic [9:0] u1, v1, src_row, src_col;
    logic       hit1, in_x, in_y;
    heading_t   head1;
    logic [11:0] addr_nxt;

    assign in_x = ({1'b0, Val_Col_In} >= {1'b0, x_q}) && ({1'b0, Val_Col_In} <= {1'b0, x_q} + S1W);
    assign in_y = ({1'b0, Val_Row_In} >= {1'b0, y_q}) && ({1'b0, Val_Row_In} <= {1'b0, y_q} + S1W);

    // stage 1: sprite-relative offsets and hit
    always_ff @(posedge Master_Clock_In or posedge Reset_In)
        if (Reset_In) begin
            u1    <= '0;
            v1    <= '0;
            hit1  <= 1'b0;
            head1 <= HEAD_UP;
        end else begin
            u1    <= Val_Col_In - x_q;
            v1    <= Val_Row_In - y_q;
            hit1  <= in_x & in_y;
            head1 <= head_q;
        end

    // rotate offsets into ROM source coordinates according to heading
    always_comb begin
        src_row  = head1 == HEAD_UP ? v1 : head1 == HEAD_DOWN ? S1 - v1 : head1 == HEAD_RIGHT ? S1 - u1 : u1;
        src_col  = head1 == HEAD_UP ? u1 : head1 == HEAD_DOWN ? S1 - u1 : head1 == HEAD_RIGHT ? v1 : S1 - v1;
        addr_nxt = hit1 ? {2'b0, src_row} * SS + {2'b0, src_col} : '0;
    end

    // stage 2: registered hit and ROM address
    always_ff @(posedge Master_Clock_In or posedge Reset_In)
        if (Reset_In) begin
            Sprite_Hit_Out  <= 1'b0;
            Sprite_Addr_Out <= '0;
        end else begin
            Sprite_Hit_Out  <= hit1;
            Sprite_Addr_Out <= addr_nxt;
        end

endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed stimulus with a queue scoreboard for the pixel pipeline.
module tb_tank_motion_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst, tick;
    logic [9:0]  col, row;
    logic        bu, bd, bl, br;
    logic [9:0]  xo, yo;
    logic [1:0]  ho;
    logic        hit;
    logic [11:0] addr;

    int checks = 0;
    int errors = 0;

    logic [12:0] exp_q[$];
    logic [12:0] sb_e;
    logic        pix_drv = 1'b0;
    logic [1:0]  sb_v;

    int         ex, ey;
    logic [1:0] eh;

    always #5 clk = ~clk;

    tank_motion_ctrl #(.Debounce_Cycles(DB)) dut (
        .Master_Clock_In(clk),
        .Reset_In       (rst),
        .Frame_Tick_In  (tick),
        .Val_Col_In     (col),
        .Val_Row_In     (row),
        .Up             (bu),
        .Down           (bd),
        .Left           (bl),
        .Right          (br),
        .xPosition_Out  (xo),
        .yPosition_Out  (yo),
        .Heading_Out    (ho),
        .Sprite_Hit_Out (hit),
        .Sprite_Addr_Out(addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] exp_pix(input int c, input int r, input int x, input int y, input logic [1:0] h);
        int u, v, sr, sc;
        u = c - x;
        v = r - y;
        if (u < 0 || u > 59 || v < 0 || v > 59) return 13'd0;
        case (h)
            2'b00:   begin sr = v;      sc = u;      end
            2'b10:   begin sr = 59 - v; sc = 59 - u; end
            2'b01:   begin sr = 59 - u; sc = v;      end
            default: begin sr = u;      sc = 59 - v; end
        endcase
        return {1'b1, 12'(sr * 60 + sc)};
    endfunction

    always @(posedge clk or posedge rst)
        if (rst) sb_v <= 2'b00;
        else     sb_v <= {sb_v[0], pix_drv};

    always @(negedge clk)
        if (sb_v[1] && !rst) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                sb_e = exp_q.pop_front();
                chk("pix_hit", {31'd0, hit}, {31'd0, sb_e[12]});
                chk("pix_addr", {20'd0, addr}, {20'd0, sb_e[11:0]});
            end
        end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        bu = u; bd = d; bl = l; br = r;
        step(DB + 4);
    endtask

    task automatic do_tick();
        logic mu, md, ml, mr;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(2);
        mu = bu & ~bd; md = bd & ~bu; ml = bl & ~br; mr = br & ~bl;
        if (ml)      ex = (ex == 0) ? 580 : ex - 1;
        else if (mr) ex = (ex == 580) ? 0 : ex + 1;
        if (mu)      ey = (ey == 0) ? 420 : ey - 1;
        else if (md) ey = (ey == 420) ? 0 : ey + 1;
        eh = mu ? 2'b00 : md ? 2'b10 : mr ? 2'b01 : ml ? 2'b11 : eh;
    endtask

    task automatic check_pos(input string tag);
        chk({tag, "_x"}, xo, ex);
        chk({tag, "_y"}, yo, ey);
        chk({tag, "_h"}, ho, eh);
    endtask

    task automatic pix(input int c, input int r, input logic [12:0] e);
        col = 10'(c);
        row = 10'(r);
        pix_drv = 1'b1;
        exp_q.push_back(e);
        step(1);
        pix_drv = 1'b0;
    endtask

    task automatic pixm(input int c, input int r);
        pix(c, r, exp_pix(c, r, ex, ey, eh));
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; col = '0; row = '0;
        bu = 0; bd = 0; bl = 0; br = 0;
        ex = 290; ey = 210; eh = 2'b00;
        step(3);
        chk("rst_x", xo, 290);
        chk("rst_y", yo, 210);
        chk("rst_h", ho, 0);
        chk("rst_hit", hit, 0);
        chk("rst_addr", addr, 0);
        rst = 1'b0;
        step(2);

        press(0, 0, 0, 1);
        repeat (3) do_tick();
        chk("right3_x", xo, 293);
        chk("right3_y", yo, 210);
        chk("right3_h", ho, 1);

        press(0, 0, 1, 0);
        repeat (293) do_tick();
        chk("left_to0_x", xo, 0);
        do_tick();
        chk("left_wrap_x", xo, 580);
        chk("left_wrap_h", ho, 3);
        do_tick();
        press(0, 0, 0, 1);
        do_tick();
        chk("right_580_x", xo, 580);
        do_tick();
        chk("right_wrap_x", xo, 0);
        check_pos("after_xwrap");

        press(0, 1, 0, 0);
        repeat (210) do_tick();
        chk("down_to420_y", yo, 420);
        do_tick();
        chk("down_wrap_y", yo, 0);
        chk("down_wrap_h", ho, 2);
        press(1, 0, 0, 0);
        do_tick();
        chk("up_wrap_y", yo, 420);
        chk("up_wrap_h", ho, 0);

        press(1, 1, 0, 1);
        do_tick();
        chk("udr_y", yo, 420);
        chk("udr_x", xo, 1);
        chk("udr_h", ho, 1);

        press(0, 0, 0, 0);
        repeat (3) begin
            bl = 1'b1; step(3);
            bl = 1'b0; step(2);
        end
        step(DB + 4);
        do_tick();
        chk("bounce_x", xo, 1);
        chk("bounce_y", yo, 420);
        chk("bounce_h", ho, 1);

        rst = 1'b1; step(1); rst = 1'b0; step(1);
        ex = 290; ey = 210; eh = 2'b00;
        check_pos("rst2");

        pix(290, 210, {1'b1, 12'd0});
        pix(349, 269, {1'b1, 12'd3599});
        pix(350, 210, 13'd0);
        pixm(289, 210);
        pixm(290, 270);
        pixm(300, 215);
        pixm(349, 209);
        step(3);

        press(0, 1, 0, 0);
        do_tick();
        press(0, 0, 0, 0);
        pix(290, 211, {1'b1, 12'd3599});
        pixm(300, 216);
        step(3);

        press(0, 0, 0, 1);
        do_tick();
        press(0, 0, 0, 0);
        pixm(291, 211);
        pixm(301, 216);
        pixm(351, 211);
        step(3);

        press(0, 0, 1, 0);
        do_tick();
        press(0, 0, 0, 0);
        pixm(290, 211);
        pixm(300, 216);
        pixm(349, 270);
        step(3);
        check_pos("pre_async");

        press(0, 0, 0, 1);
        do_tick();
        pixm(291, 211);
        pixm(300, 220);
        col = 10'd295; row = 10'd215;
        #2 rst = 1'b1;
        #1;
        chk("async_x", xo, 290);
        chk("async_y", yo, 210);
        chk("async_hit", hit, 0);
        chk("async_addr", addr, 0);
        exp_q.delete();
        ex = 290; ey = 210; eh = 2'b00;
        rst = 1'b0;
        step(DB + 4);

        tick = 1'b1;
        step(1);
        tick = 1'b0;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        step(3);
        chk("pend_discard_x", xo, 290);
        step(DB + 4);
        do_tick();
        chk("post_rst_x", xo, 291);
        check_pos("post_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
